issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Selects ready reservation-station entries and dispatches them to the three functional units: FU0 = ALU0, FU1 = ALU1, FU2 = LSU.
- Sits between the reservation station and the execute/issue datapath.
- Owns FU occupancy tracking, oldest-first arbitration and in-order memory issue.
- Drives the func_units enable mask consumed by the execute stage.

Parameters:
- RS_DEPTH, 8, number of reservation-station entries (power of 2).
- IDX_W, 3, entry index width, equal to log2(RS_DEPTH).
- ALU_LAT, 1, ALU occupancy in cycles (1..15).
- LSU_LAT, 2, LSU occupancy in cycles (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- rs_valid  in  RS_DEPTH  entry holds an instruction.
- rs_ready  in  RS_DEPTH  entry operands available.
- rs_class  in  2*RS_DEPTH  per-entry class: 00 ALU, 01 LSU, 1x illegal (never issued).
- rs_head  in  IDX_W  index of the oldest entry; age increases with index modulo RS_DEPTH.
- issue_valid  out  3  per-FU dispatch strobe.
- issue_idx  out  3*IDX_W  per-FU selected entry; FU n occupies bits [n*IDX_W +: IDX_W].
- rs_clear  out  RS_DEPTH  entries dispatched this cycle.
- func_units  out  3  per-FU dispatch enable for the execute stage (1 = dispatch this cycle).
- fu_done  out  3  one-cycle completion pulse per FU.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - issue_valid = 0, issue_idx = 0, rs_clear = 0, fu_done = 0, func_units = 3'b000.
  - Busy counters = 0, excluded mask = 0.
  - Deasserting rst_n in the middle of an operation abandons any in-flight FU occupancy.
- Eligible entry: rs_valid & rs_ready & class legal & not in the excluded mask.
  - Excluded mask = previous cycle's rs_clear. This covers the one-cycle RS clear latency.
- Free FU: its counter is 0 or 1, evaluated at the edge.
  - Result: with LAT = 1 an FU can be dispatched back-to-back every cycle.
  - With LAT = N, consecutive dispatches to one FU are N cycles apart.
- ALU arbitration:
  - Scan eligible ALU-class entries from rs_head upward, wrapping at RS_DEPTH.
  - If FU0 is free, FU0 takes the oldest entry; if FU1 is also free, FU1 takes the second-oldest.
  - If only FU1 is free, FU1 takes the oldest.
  - An entry is never picked by both FUs.
- LSU arbitration (in-order):
  - Find the oldest rs_valid LSU-class entry, regardless of ready.
  - Dispatch it only if it is eligible and FU2 is free.
  - A younger ready LSU entry never bypasses an older unready one.
- Outputs are registered; all updates happen at the same edge:
  - issue_valid[n] = 1 and issue_idx slice n = the selected index.
  - rs_clear bit of each selected entry = 1.
  - func_units = issue_valid.
  - Counter of each dispatched FU is loaded with its LAT.
  - Every other nonzero counter decrements by 1.
- fu_done[n] pulses for one cycle when counter n goes 1→0.
  - It also pulses when counter n is 1 and the FU is reloaded at the same edge; in that case the pulse reports the previous operation.
- flush = 1:
  - At that edge issue_valid, rs_clear and func_units are forced to 0, and no counter is loaded.
  - Counters still decrement and fu_done still pulses: in-flight operations drain.
  - The excluded mask is cleared.
- Simultaneous flush and rst_n = 0: reset wins.
- No eligible entries: all strobes 0; counters keep draining.
- rs_head wrap: a scan starting at RS_DEPTH-1 continues at index 0.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined:
  - Adds output stall_cnt, 48 bits: three 16-bit saturating counters, FU n in bits [16n +: 16].
  - Counter n increments each cycle that an eligible candidate of FU n's class exists but FU n is not free.
  - For the ALUs, the candidate count must exceed the number of free ALUs.
  - Counters saturate at 16'hFFFF, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then entries 2 and 5 valid/ready ALU with rs_head = 0 → next cycle issue_valid = 3'b011, FU0 idx = 2, FU1 idx = 5, rs_clear = 8'b0010_0100. Hold inputs one more cycle → no re-issue of 2 or 5.
- LSU entries 1 (not ready) and 3 (ready), rs_head = 0 → issue_valid[2] = 0 for as long as entry 1 is unready. Set rs_ready[1] = 1 → FU2 idx = 1. FU2 dispatches idx 3 two cycles after idx 1 (LSU_LAT = 2).
- rs_head = 6, ALU entries 7 and 0 ready → FU0 idx = 7, FU1 idx = 0 (wrap ordering).
- LSU_LAT = 2, LSU entries 0, 1, 2 continuously ready → FU2 dispatches every 2nd cycle; fu_done[2] pulses 2 cycles after each dispatch.
- Dispatch to FU2, then flush on the next edge → issue_valid = 0 and rs_clear = 0 that cycle; fu_done[2] still pulses on schedule.
- With ISSUE_STATS_EN: 3 ALU entries ready, both ALUs free, ALU_LAT = 1, 1 cycle → stall_cnt[15:0] = 1 and stall_cnt[31:16] = 1.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: reservation-station / issue bus between the RS and the issue scheduler.
// stall_cnt exists only when ISSUE_STATS_EN is defined.
interface issue_scheduler_if #(parameter int RS_DEPTH = 8, parameter int IDX_W = 3);
  logic                  flush;
  logic [RS_DEPTH-1:0]   rs_valid;
  logic [RS_DEPTH-1:0]   rs_ready;
  logic [2*RS_DEPTH-1:0] rs_class;
  logic [IDX_W-1:0]      rs_head;
  logic [2:0]            issue_valid;
  logic [3*IDX_W-1:0]    issue_idx;
  logic [RS_DEPTH-1:0]   rs_clear;
  logic [2:0]            func_units;
  logic [2:0]            fu_done;
`ifdef ISSUE_STATS_EN
  logic [47:0]           stall_cnt;
`endif
  modport master (
    output flush, rs_valid, rs_ready, rs_class, rs_head,
    input  issue_valid, issue_idx, rs_clear, func_units, fu_done
`ifdef ISSUE_STATS_EN
    , input stall_cnt
`endif
  );
  modport slave (
    input  flush, rs_valid, rs_ready, rs_class, rs_head,
    output issue_valid, issue_idx, rs_clear, func_units, fu_done
`ifdef ISSUE_STATS_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler: oldest-first dispatch to ALU0/ALU1/LSU with FU occupancy and in-order memory issue.
// ISSUE_STATS_EN adds per-FU saturating stall counters on stall_cnt.
module issue_scheduler #(
  parameter int RS_DEPTH = 8,
  parameter int IDX_W    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LSU_LAT  = 2
) (
  input logic clk,
  input logic rst_n,
  issue_scheduler_if.slave bus
);
  logic [RS_DEPTH-1:0] alu_m, lsu_m, elig, clr_nx;
  logic [3:0]          cnt [3];
  logic [2:0]          free, sel;
  logic [IDX_W-1:0]    idx [3];
  logic [IDX_W-1:0]    j, a0, a1, l_idx;
  logic                a0_v, a1_v, l_v;
  // Entries shown in rs_clear are still visible for one cycle and must not be re-picked.
  assign elig = bus.rs_valid & bus.rs_ready & ~bus.rs_clear;
  always_comb begin
    alu_m = '0;
    lsu_m = '0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      alu_m[k] = bus.rs_class[2*k +: 2] == 2'b00;
      lsu_m[k] = bus.rs_class[2*k +: 2] == 2'b01;
    end
    for (int n = 0; n < 3; n++) free[n] = cnt[n] <= 4'd1;
  end
  // Age scan from rs_head with wrap; the LSU pick ignores ready to keep memory ops in order.
  always_comb begin
    j = '0;
    a0 = '0;
    a1 = '0;
    l_idx = '0;
    a0_v = 1'b0;
    a1_v = 1'b0;
    l_v = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      j = bus.rs_head + IDX_W'(i);
      if (elig[j] && alu_m[j] && a0_v && !a1_v) begin
        a1 = j;
        a1_v = 1'b1;
      end
      if (elig[j] && alu_m[j] && !a0_v) begin
        a0 = j;
        a0_v = 1'b1;
      end
      if (bus.rs_valid[j] && lsu_m[j] && !bus.rs_clear[j] && !l_v) begin
        l_idx = j;
        l_v = 1'b1;
      end
    end
  end
  always_comb begin
    sel[0] = free[0] & a0_v;
    sel[1] = free[1] & (free[0] ? a1_v : a0_v);
    sel[2] = free[2] & l_v & elig[l_idx];
    idx[0] = a0;
    idx[1] = free[0] ? a1 : a0;
    idx[2] = l_idx;
    clr_nx = '0;
    for (int n = 0; n < 3; n++) if (sel[n]) clr_nx[idx[n]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.issue_valid <= '0;
      bus.issue_idx   <= '0;
      bus.rs_clear    <= '0;
      bus.func_units  <= '0;
      bus.fu_done     <= '0;
      for (int n = 0; n < 3; n++) cnt[n] <= '0;
    end else begin
      bus.issue_valid <= bus.flush ? 3'b000 : sel;
      bus.func_units  <= bus.flush ? 3'b000 : sel;
      bus.issue_idx   <= {idx[2], idx[1], idx[0]};
      bus.rs_clear    <= bus.flush ? '0 : clr_nx;
      for (int n = 0; n < 3; n++) begin
        bus.fu_done[n] <= cnt[n] == 4'd1;
        cnt[n] <= (sel[n] && !bus.flush) ? (n == 2 ? 4'(LSU_LAT) : 4'(ALU_LAT)) : cnt[n] - 4'(cnt[n] != 4'd0);
      end
    end
  end
`ifdef ISSUE_STATS_EN
  logic [1:0] a_n, nfree;
  logic [2:0] stall;
  // ALU stalls count when ready ALU work outnumbers the free ALUs.
  always_comb begin
    a_n = '0;
    for (int i = 0; i < RS_DEPTH; i++) if (elig[i] && alu_m[i] && a_n != 2'd3) a_n = a_n + 2'd1;
    nfree = 2'(free[0]) + 2'(free[1]);
    stall = {~free[2] & |(elig & lsu_m), {2{a_n > nfree}}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.stall_cnt <= '0;
    else
      for (int n = 0; n < 3; n++)
        if (stall[n] && bus.stall_cnt[16*n +: 16] != 16'hFFFF)
          bus.stall_cnt[16*n +: 16] <= bus.stall_cnt[16*n +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed vectors with hand-computed expectations for issue_scheduler.
module tb_issue_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int iv [7] = '{1, 0, 1, 0, 1, 0, 0};
  int ix [7] = '{0, 0, 1, 0, 2, 0, 0};
  int fd [7] = '{0, 0, 1, 0, 1, 0, 1};
  issue_scheduler_if #(.RS_DEPTH(8), .IDX_W(3)) bus ();
  issue_scheduler #(.RS_DEPTH(8), .IDX_W(3), .ALU_LAT(1), .LSU_LAT(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] v, input logic [7:0] r, input logic [15:0] c, input logic [2:0] h);
    bus.rs_valid = v;
    bus.rs_ready = r;
    bus.rs_class = c;
    bus.rs_head  = h;
  endtask
  // One clock; the RS drops entries one edge after it sees them in rs_clear.
  task automatic tick;
    logic [7:0] clr;
    clr = bus.rs_clear;
    @(posedge clk);
    #1;
    bus.rs_valid = bus.rs_valid & ~clr;
  endtask
  task automatic drain;
    drive(8'h00, 8'h00, 16'h0000, 3'd0);
    repeat (4) tick();
  endtask
  initial begin
    bus.flush = 1'b0;
    drive(8'h00, 8'h00, 16'h0000, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_issue_valid", 48'(bus.issue_valid), 48'h0);
    check("rst_issue_idx", 48'(bus.issue_idx), 48'h0);
    check("rst_rs_clear", 48'(bus.rs_clear), 48'h0);
    check("rst_func_units", 48'(bus.func_units), 48'h0);
    check("rst_fu_done", 48'(bus.fu_done), 48'h0);
`ifdef ISSUE_STATS_EN
    check("rst_stall_cnt", bus.stall_cnt, 48'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(8'h24, 8'h24, 16'h0000, 3'd0);
    tick();
    check("t1_issue_valid", 48'(bus.issue_valid), 48'h3);
    check("t1_fu0_idx", 48'(bus.issue_idx[2:0]), 48'd2);
    check("t1_fu1_idx", 48'(bus.issue_idx[5:3]), 48'd5);
    check("t1_rs_clear", 48'(bus.rs_clear), 48'h24);
    check("t1_func_units", 48'(bus.func_units), 48'h3);
    tick();
    check("t1_no_reissue", 48'(bus.issue_valid), 48'h0);
    check("t1_clear_idle", 48'(bus.rs_clear), 48'h0);
    check("t1_fu_done", 48'(bus.fu_done), 48'h3);
    tick();
    check("t1_fu_done_end", 48'(bus.fu_done), 48'h0);
    drain();
    drive(8'h0A, 8'h08, 16'h0044, 3'd0);
    tick();
    check("t2_blocked_a", 48'(bus.issue_valid), 48'h0);
    tick();
    check("t2_blocked_b", 48'(bus.issue_valid), 48'h0);
    bus.rs_ready = 8'h0A;
    tick();
    check("t2_lsu_valid_1", 48'(bus.issue_valid), 48'h4);
    check("t2_lsu_idx_1", 48'(bus.issue_idx[8:6]), 48'd1);
    check("t2_clear_1", 48'(bus.rs_clear), 48'h02);
    tick();
    check("t2_lsu_busy", 48'(bus.issue_valid), 48'h0);
    tick();
    check("t2_lsu_valid_3", 48'(bus.issue_valid), 48'h4);
    check("t2_lsu_idx_3", 48'(bus.issue_idx[8:6]), 48'd3);
    check("t2_done_1", 48'(bus.fu_done), 48'h4);
    tick();
    check("t2_done_gap", 48'(bus.fu_done), 48'h0);
    tick();
    check("t2_done_3", 48'(bus.fu_done), 48'h4);
    drain();
    drive(8'h81, 8'h81, 16'h0000, 3'd6);
    tick();
    check("t3_issue_valid", 48'(bus.issue_valid), 48'h3);
    check("t3_fu0_idx", 48'(bus.issue_idx[2:0]), 48'd7);
    check("t3_fu1_idx", 48'(bus.issue_idx[5:3]), 48'd0);
    drain();
    drive(8'h07, 8'h07, 16'h0015, 3'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("t4_valid_%0d", i), 48'(bus.issue_valid[2]), 48'(iv[i]));
      if (iv[i] != 0) check($sformatf("t4_idx_%0d", i), 48'(bus.issue_idx[8:6]), 48'(ix[i]));
      check($sformatf("t4_done_%0d", i), 48'(bus.fu_done[2]), 48'(fd[i]));
    end
    drain();
    drive(8'h10, 8'h10, 16'h0100, 3'd0);
    tick();
    check("t5_lsu_valid", 48'(bus.issue_valid), 48'h4);
    check("t5_lsu_idx", 48'(bus.issue_idx[8:6]), 48'd4);
    bus.flush = 1'b1;
    bus.rs_valid = bus.rs_valid | 8'h40;
    bus.rs_ready = bus.rs_ready | 8'h40;
    tick();
    bus.flush = 1'b0;
    check("t5_flush_valid", 48'(bus.issue_valid), 48'h0);
    check("t5_flush_clear", 48'(bus.rs_clear), 48'h0);
    check("t5_flush_fu", 48'(bus.func_units), 48'h0);
    tick();
    check("t5_drain_done", 48'(bus.fu_done), 48'h4);
    check("t5_after_valid", 48'(bus.issue_valid), 48'h1);
    check("t5_after_idx", 48'(bus.issue_idx[2:0]), 48'd6);
    drain();
    drive(8'h03, 8'h03, 16'h000E, 3'd0);
    tick();
    tick();
    check("t6_illegal", 48'(bus.issue_valid), 48'h0);
    drain();
    drive(8'h01, 8'h01, 16'h0001, 3'd0);
    tick();
    check("t7_lsu_valid", 48'(bus.issue_valid), 48'h4);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 48'(bus.issue_valid), 48'h0);
    check("t7_rst_clear", 48'(bus.rs_clear), 48'h0);
    drive(8'h00, 8'h00, 16'h0000, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    check("t7_abandoned", 48'(bus.fu_done), 48'h0);
`ifdef ISSUE_STATS_EN
    check("t8_stall_zero", bus.stall_cnt, 48'h0);
`endif
    drive(8'h07, 8'h07, 16'h0000, 3'd0);
    tick();
    check("t8_issue_valid", 48'(bus.issue_valid), 48'h3);
    check("t8_fu0_idx", 48'(bus.issue_idx[2:0]), 48'd0);
    check("t8_fu1_idx", 48'(bus.issue_idx[5:3]), 48'd1);
`ifdef ISSUE_STATS_EN
    check("t8_stall_alu0", 48'(bus.stall_cnt[15:0]), 48'd1);
    check("t8_stall_alu1", 48'(bus.stall_cnt[31:16]), 48'd1);
    check("t8_stall_lsu", 48'(bus.stall_cnt[47:32]), 48'd0);
`endif
    tick();
    check("t8_third_valid", 48'(bus.issue_valid), 48'h1);
    check("t8_third_idx", 48'(bus.issue_idx[2:0]), 48'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
